// File: rtl/simple_transmitter.sv
// simple_transmitter: UART transmitter that pops words from a standard FIFO and sends start/data/parity/stop frames on tx.
// Ports:
//   clk    - single clock, all logic on posedge
//   rst_n  - asynchronous active-low reset
//   din    - FIFO read data, valid the cycle after re
//   empty  - FIFO empty flag
//   re     - FIFO read enable, one pulse per frame
//   tx     - serial line, idle high, registered
//   busy   - high whenever a frame is being loaded or sent
module simple_transmitter #(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter logic [31:0] WORD_WIDTH      = 32'd8,
    parameter logic [31:0] PARITY          = 32'd0,
    parameter logic [31:0] STOP_BITS       = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  empty,
    output logic                  re,
    output logic                  tx,
    output logic                  busy
);
    localparam int CPB = int'(CLOCK_FREQUENCY / BAUD_RATE);
    localparam int W   = int'(WORD_WIDTH);
    localparam int CW  = CPB > 1 ? $clog2(CPB) : 1;
    localparam int BW  = W > 1 ? $clog2(W) : 1;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    if (CPB < 2) begin : g_bad_cpb
        $error("CLOCKS_PER_BIT must be at least 2");
    end
    if (PARITY > 32'd2) begin : g_bad_parity
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 32'd1 && STOP_BITS != 32'd2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (W < 1) begin : g_bad_width
        $error("WORD_WIDTH must be at least 1");
    end

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bit;
    logic          r_stop;
    logic [W-1:0]  r_shift;
    logic          r_par;
    logic          r_tx;
    logic          w_last;
    logic          w_par;
    logic [W-1:0]  w_shift_nxt;

    assign w_last      = r_cnt == CW'(CPB - 1);
    // parity is latched with the word so a changing din cannot disturb it
    assign w_par       = (PARITY == 32'd2) ? ^din : ~^din;
    // shift right, back-filling with ones so the register drains to idle level
    assign w_shift_nxt = W'({1'b1, r_shift} >> 1);
    // gated by rst_n so no read can be issued while reset is held
    assign re          = rst_n & (r_state == S_IDLE) & ~empty;
    assign busy        = r_state != S_IDLE;
    assign tx          = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '1;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_cnt <= (r_state == S_IDLE || r_state == S_LOAD || w_last) ? '0 : r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_bit  <= '0;
                    r_stop <= 1'b0;
                    if (!empty) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift <= din;
                    r_par   <= w_par;
                    r_tx    <= 1'b0;
                    r_state <= S_START;
                end
                S_START: if (w_last) begin
                    r_tx    <= r_shift[0];
                    r_shift <= w_shift_nxt;
                    r_state <= S_DATA;
                end
                S_DATA: if (w_last) begin
                    if (r_bit == BW'(W - 1)) begin
                        r_bit   <= '0;
                        r_tx    <= (PARITY != 32'd0) ? r_par : 1'b1;
                        r_state <= (PARITY != 32'd0) ? S_PARITY : S_STOP;
                    end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_tx    <= r_shift[0];
                        r_shift <= w_shift_nxt;
                    end
                end
                S_PARITY: if (w_last) begin
                    r_tx    <= 1'b1;
                    r_state <= S_STOP;
                end
                S_STOP: if (w_last) begin
                    if (r_stop == 1'(STOP_BITS - 32'd1)) begin
                        r_stop  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_stop <= r_stop + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simple_transmitter.sv
// tb_simple_transmitter: scoreboard bench running four frame formats side by side from identical FIFO contents.
module tb_simple_transmitter;
    localparam int CPB = 10;
    localparam int N   = 4;

    function automatic int par_of(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction
    function automatic int stop_of(input int k);
        return (k >= 2) ? 2 : 1;
    endfunction
    function automatic int frame_bits(input int k);
        return 9 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
    endfunction
    // expected line level for bit slot idx of a frame carrying w
    function automatic int exp_level(input int k, input logic [7:0] w, input int idx);
        int ones;
        ones = $countones(w);
        if (idx == 0) return 0;
        if (idx <= 8) return int'(w[idx-1]);
        if (par_of(k) != 0 && idx == 9) return (par_of(k) == 2) ? ones % 2 : 1 - ones % 2;
        return 1;
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] fq  [N][$];
    logic [7:0] exq [N][$];
    logic [7:0] din     [N];
    logic       empty_v [N] = '{default: 1'b1};
    logic       hold    [N] = '{default: 1'b0};
    logic       re_v    [N];
    logic       tx_v    [N];
    logic       busy_v  [N];
    bit         in_frame[N];
    int         pos     [N];
    logic [7:0] cur_w   [N];
    int         re_cnt  [N] = '{default: 0};
    int         re_cyc  [N] = '{default: -10};
    int         end_cyc [N] = '{default: -10};

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int P = par_of(g);
        localparam int S = stop_of(g);
        simple_transmitter #(
            .CLOCK_FREQUENCY(32'd1_000_000),
            .BAUD_RATE(32'd100_000),
            .WORD_WIDTH(32'd8),
            .PARITY(32'(P)),
            .STOP_BITS(32'(S))
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .din(din[g]),
            .empty(empty_v[g]),
            .re(re_v[g]),
            .tx(tx_v[g]),
            .busy(busy_v[g])
        );
    end

    task automatic chk(input string name, input int k, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut%0d at cycle %0d: got %0d, expected %0d", name, k, cyc, act, req);
        end
    endtask

    // FIFO model: a popped word appears on din the next cycle and its frame is queued as expected
    always @(posedge clk) begin : fifo
        logic [7:0] w;
        for (int k = 0; k < N; k++) begin
            if (re_v[k] && fq[k].size() > 0) begin
                w = fq[k].pop_front();
                din[k] <= w;
                exq[k].push_back(w);
            end else begin
                din[k] <= 8'($urandom);
            end
            empty_v[k] <= hold[k] || fq[k].size() == 0;
        end
    end

    // monitor: decodes tx every cycle against the expected frame at the head of the scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                chk("re_in_reset", k, int'(re_v[k]), 0);
                in_frame[k] = 1'b0;
                exq[k].delete();
            end else begin
                if (re_v[k]) begin
                    re_cnt[k]++;
                    re_cyc[k] = cyc;
                    chk("re_when_empty", k, int'(empty_v[k]), 0);
                    chk("busy_at_re", k, int'(busy_v[k]), 0);
                end
                if (!in_frame[k] && cyc == end_cyc[k] + 1) begin
                    chk("busy_after_stop", k, int'(busy_v[k]), 0);
                    chk("re_after_stop", k, int'(re_v[k]), int'(!empty_v[k]));
                end
                if (!in_frame[k] && !tx_v[k]) begin
                    if (exq[k].size() == 0) begin
                        chk("start_without_word", k, int'(tx_v[k]), 1);
                    end else begin
                        cur_w[k] = exq[k].pop_front();
                        in_frame[k] = 1'b1;
                        pos[k] = 0;
                        chk("re_to_start", k, cyc - re_cyc[k], 2);
                    end
                end
                if (in_frame[k]) begin
                    chk("tx_level", k, int'(tx_v[k]), exp_level(k, cur_w[k], pos[k] / CPB));
                    chk("busy_in_frame", k, int'(busy_v[k]), 1);
                    pos[k]++;
                    if (pos[k] == frame_bits(k) * CPB) begin
                        in_frame[k] = 1'b0;
                        end_cyc[k] = cyc;
                    end
                end
            end
        end
    end

    task automatic push_all(input logic [7:0] w);
        @(negedge clk);
        for (int k = 0; k < N; k++) fq[k].push_back(w);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 4000 && !done; t++) begin
            @(negedge clk);
            done = 1'b1;
            for (int k = 0; k < N; k++)
                if (fq[k].size() != 0 || exq[k].size() != 0 || in_frame[k] || busy_v[k]) done = 1'b0;
        end
        if (!done) chk("wait_idle_timeout", 0, 0, 1);
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = in_frame[0];
        end
        if (!seen) chk("wait_start_timeout", 0, 0, 1);
    endtask

    task automatic check_re_cnt(input int req);
        for (int k = 0; k < N; k++) chk("re_count", k, re_cnt[k], req);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("empty_no_re", k, re_cnt[k], 0);
            chk("empty_tx_idle", k, int'(tx_v[k]), 1);
        end
        push_all(8'h55);
        @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) chk("re_idle_nonempty", k, int'(re_v[k]), 1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("async_reset_re", k, int'(re_v[k]), 0);
            chk("async_reset_tx", k, int'(tx_v[k]), 1);
            chk("async_reset_busy", k, int'(busy_v[k]), 0);
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_idle();
        check_re_cnt(1);
        push_all(8'hA3);
        wait_idle();
        check_re_cnt(2);
        push_all(8'h00);
        push_all(8'hFF);
        wait_idle();
        check_re_cnt(4);
        push_all(8'h3C);
        push_all(8'h77);
        wait_start();
        repeat (30) @(negedge clk);
        for (int k = 0; k < N; k++) hold[k] = 1'b1;
        repeat (150) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("held_word_kept", k, fq[k].size(), 1);
            chk("held_no_re", k, re_cnt[k], 5);
            chk("held_tx_idle", k, int'(tx_v[k]), 1);
        end
        for (int k = 0; k < N; k++) hold[k] = 1'b0;
        wait_idle();
        check_re_cnt(6);
        push_all(8'h0F);
        push_all(8'h5A);
        wait_start();
        repeat (35) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("midframe_reset_tx", k, int'(tx_v[k]), 1);
            chk("midframe_reset_busy", k, int'(busy_v[k]), 0);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_idle();
        check_re_cnt(8);
        for (int i = 0; i < 10; i++) begin
            push_all(8'($urandom));
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        wait_idle();
        check_re_cnt(18);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
